// File: rtl/id_operand_fetch_if.sv
// ID-stage / regfile / forwarding / ID-EX bundle for id_operand_fetch.
// slave is the operand-fetch block's view; master is the surrounding pipeline's view.
interface id_operand_fetch_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int CNTW = 16
);
  logic            id_valid;
  logic            id_ready;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_rs_re;
  logic            id_rt_re;
  logic [DW-1:0]   id_imm;
  logic [AW-1:0]   id_waddr;
  logic            id_we;
  logic            id_is_load;
  logic [OPW-1:0]  id_aluop;

  logic [AW-1:0]   raddr1;
  logic            re1;
  logic [AW-1:0]   raddr2;
  logic            re2;
  logic [DW-1:0]   rdata1;
  logic [DW-1:0]   rdata2;

  logic            ex_fwd_we;
  logic [AW-1:0]   ex_fwd_waddr;
  logic [DW-1:0]   ex_fwd_wdata;
  logic            ex_fwd_is_load;
  logic            mem_fwd_we;
  logic [AW-1:0]   mem_fwd_waddr;
  logic [DW-1:0]   mem_fwd_wdata;

  logic            ex_stall;
  logic            flush;

  logic            ex_valid;
  logic [OPW-1:0]  ex_aluop;
  logic [DW-1:0]   ex_reg1;
  logic [DW-1:0]   ex_reg2;
  logic [AW-1:0]   ex_waddr;
  logic            ex_we;
  logic            ex_is_load;
  logic            stall_req;
  logic [CNTW-1:0] interlock_cnt;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_re, id_rt_re, id_imm, id_waddr, id_we, id_is_load, id_aluop,
    input  rdata1, rdata2,
    input  ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata, ex_fwd_is_load,
    input  mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata,
    input  ex_stall, flush,
    output id_ready, raddr1, re1, raddr2, re2,
    output ex_valid, ex_aluop, ex_reg1, ex_reg2, ex_waddr, ex_we, ex_is_load,
    output stall_req, interlock_cnt
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rs_re, id_rt_re, id_imm, id_waddr, id_we, id_is_load, id_aluop,
    output rdata1, rdata2,
    output ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata, ex_fwd_is_load,
    output mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata,
    output ex_stall, flush,
    input  id_ready, raddr1, re1, raddr2, re2,
    input  ex_valid, ex_aluop, ex_reg1, ex_reg2, ex_waddr, ex_we, ex_is_load,
    input  stall_req, interlock_cnt
  );
endinterface

// File: rtl/id_operand_fetch.sv
// Operand fetch with EX/MEM forwarding, load-use interlock and ID/EX register; 1-cycle latency,
// +1 bubble on load-use. ex_stall holds the register and withdraws id_ready; flush kills it.
module id_operand_fetch #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int CNTW = 16
) (
  input  logic clk,
  input  logic rst,
  id_operand_fetch_if.slave bus
);

  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] aluop;
    logic [DW-1:0]  reg1;
    logic [DW-1:0]  reg2;
    logic [AW-1:0]  waddr;
    logic           we;
    logic           is_load;
  } idex_t;

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t          state, state_nxt;
  idex_t           idex_q, idex_d;
  logic [CNTW-1:0] cnt_q;
  logic            hazard, stall_req, id_ready, cnt_inc;
  logic [DW-1:0]   op1, op2;

  function automatic logic [DW-1:0] operand(
    input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] dflt, input logic [DW-1:0] rdata,
    input logic ex_we, input logic [AW-1:0] ex_wa, input logic [DW-1:0] ex_wd,
    input logic mem_we, input logic [AW-1:0] mem_wa, input logic [DW-1:0] mem_wd);
    if (!en)                            return dflt;
    else if (addr == '0)                return '0;
    else if (ex_we && ex_wa == addr)    return ex_wd;
    else if (mem_we && mem_wa == addr)  return mem_wd;
    else                                return rdata;
  endfunction

  always_comb begin
    op1 = operand(bus.id_rs_re, bus.id_rs, '0, bus.rdata1,
                  bus.ex_fwd_we, bus.ex_fwd_waddr, bus.ex_fwd_wdata,
                  bus.mem_fwd_we, bus.mem_fwd_waddr, bus.mem_fwd_wdata);
    op2 = operand(bus.id_rt_re, bus.id_rt, bus.id_imm, bus.rdata2,
                  bus.ex_fwd_we, bus.ex_fwd_waddr, bus.ex_fwd_wdata,
                  bus.mem_fwd_we, bus.mem_fwd_waddr, bus.mem_fwd_wdata);
  end

  always_comb begin
    hazard = bus.id_valid && bus.ex_fwd_is_load && bus.ex_fwd_we && (bus.ex_fwd_waddr != '0) &&
             ((bus.id_rs_re && (bus.id_rs == bus.ex_fwd_waddr)) ||
              (bus.id_rt_re && (bus.id_rt == bus.ex_fwd_waddr)));
    stall_req = !rst && (state == RUN) && hazard;
    id_ready  = !rst && bus.id_valid && !stall_req && !bus.ex_stall;
    cnt_inc   = stall_req && !bus.ex_stall && !bus.flush;
  end

  always_comb begin
    state_nxt = state;
    idex_d    = idex_q;
    if (bus.flush) begin
      state_nxt = RUN;
      idex_d    = '0;
    end else if (!bus.ex_stall) begin
      idex_d = '0;
      if (stall_req) begin
        state_nxt = LDSTALL;
      end else begin
        // LDSTALL lasts exactly one cycle; the load has moved to MEM by now
        state_nxt = RUN;
        if (id_ready) begin
          idex_d.valid   = 1'b1;
          idex_d.aluop   = bus.id_aluop;
          idex_d.reg1    = op1;
          idex_d.reg2    = op2;
          idex_d.waddr   = bus.id_waddr;
          idex_d.we      = bus.id_we;
          idex_d.is_load = bus.id_is_load;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      idex_q <= idex_d;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.raddr1        = bus.id_rs;
  assign bus.re1           = bus.id_rs_re & bus.id_valid;
  assign bus.raddr2        = bus.id_rt;
  assign bus.re2           = bus.id_rt_re & bus.id_valid;
  assign bus.id_ready      = id_ready;
  assign bus.stall_req     = stall_req;
  assign bus.interlock_cnt = cnt_q;
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_aluop      = idex_q.aluop;
  assign bus.ex_reg1       = idex_q.reg1;
  assign bus.ex_reg2       = idex_q.reg2;
  assign bus.ex_waddr      = idex_q.waddr;
  assign bus.ex_we         = idex_q.we;
  assign bus.ex_is_load    = idex_q.is_load;

endmodule
